// File: rtl/image_filter_core.sv
// Streaming 3x3 neighbourhood filter (identity/mean/sharpen/edge) for square 8-bit images.
// Optional IMG_BINARIZE_EN macro adds filter code 4 = threshold at 128.
module image_filter_core #(
  parameter int MAX_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] size,
  input  logic [7:0] filter,
  input  logic       validData,
  input  logic [7:0] pixel_in1,
  input  logic [7:0] pixel_in2,
  input  logic [7:0] pixel_in3,
  output logic       ValidResult,
  output logic [7:0] Pixel_address,
  output logic [7:0] pixel_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [7:0] top;
    logic [7:0] mid;
    logic [7:0] bot;
  } col_t;

  state_t     state, state_n;
  logic [7:0] size_q, filter_q, col, row;
  col_t       col_w, col_c, col_e;
  logic       start_ok, load, accept, has_win, last_col, last_row;
  logic [7:0] result, addr;

  assign col_e    = {pixel_in1, pixel_in2, pixel_in3};
  assign start_ok = start && (size >= 8'd3) && (size <= 8'(MAX_SIZE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = RUN;
      RUN:     if (accept && last_col && last_row) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    load     = (state == IDLE) && start_ok;
    accept   = (state == RUN) && validData;
    last_col = (col == size_q - 8'd1);
    last_row = (row == size_q - 8'd3);
    has_win  = accept && (col >= 8'd2);
  end

  function automatic logic [7:0] clamp(input logic signed [12:0] v);
    if (v < 0)           return 8'd0;
    else if (v > 13'sd255) return 8'd255;
    else                 return v[7:0];
  endfunction

  // Window taps: W = col_w, C = col_c (centre column), E = incoming column
  logic signed [12:0] x, n, s, wp, ep, s8, mean_q, sharp, edge_v, edge_abs;
  always_comb begin
    x  = {5'd0, col_c.mid};
    n  = {5'd0, col_c.top};
    s  = {5'd0, col_c.bot};
    wp = {5'd0, col_w.mid};
    ep = {5'd0, col_e.mid};
    s8 = {5'd0, col_w.top} + wp + {5'd0, col_w.bot} + n + s
       + {5'd0, col_e.top} + ep + {5'd0, col_e.bot};
    mean_q   = (x + s8) / 13'sd9;
    sharp    = 13'sd5 * x - n - s - wp - ep;
    edge_v   = (x <<< 3) - s8;
    edge_abs = (edge_v < 0) ? -edge_v : edge_v;
    case (filter_q)
      8'd1:    result = clamp(mean_q);
      8'd2:    result = clamp(sharp);
      8'd3:    result = clamp(edge_abs);
`ifdef IMG_BINARIZE_EN
      8'd4:    result = (col_c.mid >= 8'd128) ? 8'd255 : 8'd0;
`endif
      default: result = col_c.mid;
    endcase
    addr = (row + 8'd1) * size_q + (col - 8'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q        <= '0;
      filter_q      <= '0;
      col           <= '0;
      row           <= '0;
      col_w         <= '0;
      col_c         <= '0;
      ValidResult   <= 1'b0;
      Pixel_address <= '0;
      pixel_out     <= '0;
    end else begin
      ValidResult <= 1'b0;
      if (load) begin
        size_q   <= size;
        filter_q <= filter;
        col      <= '0;
        row      <= '0;
        col_w    <= '0;
        col_c    <= '0;
      end else if (accept) begin
        if (has_win) begin
          ValidResult   <= 1'b1;
          pixel_out     <= result;
          Pixel_address <= addr;
        end
        // Row wrap: the next row starts a fresh window
        if (last_col) begin
          col   <= '0;
          row   <= row + 8'd1;
          col_w <= '0;
          col_c <= '0;
        end else begin
          col   <= col + 8'd1;
          col_w <= col_c;
          col_c <= col_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_filter_core.sv
// Directed bench for image_filter_core: 3x3 filter vector table plus size-4 stream,
// stall, start-ignore, range and mid-frame reset sequences.
module tb_image_filter_core;

  logic       clk = 1'b0;
  logic       rst, start, validData;
  logic [7:0] size, filter, pixel_in1, pixel_in2, pixel_in3;
  logic       ValidResult;
  logic [7:0] Pixel_address, pixel_out;

  image_filter_core #(.MAX_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .filter(filter),
    .validData(validData), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
    .pixel_in3(pixel_in3), .ValidResult(ValidResult),
    .Pixel_address(Pixel_address), .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  typedef struct {
    string      nm;
    logic [7:0] f;
    logic [23:0] c0, c1, c2;   // {top, mid, bot}
    logic [7:0] e;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] s, input logic [7:0] f);
    start = 1'b1; size = s; filter = f;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input string nm, input logic [23:0] cv, input bit ev,
                      input int epix, input int eaddr);
    {pixel_in1, pixel_in2, pixel_in3} = cv;
    validData = 1'b1;
    tick();
    validData = 1'b0;
    chk({nm, " vld"}, int'(ValidResult), int'(ev));
    if (ev) begin
      chk({nm, " pix"}, int'(pixel_out), epix);
      chk({nm, " addr"}, int'(Pixel_address), eaddr);
    end
  endtask

  function automatic logic [7:0] img(input int r, input int c);
    return 8'(10 * r + c + 1);
  endfunction

  function automatic logic [23:0] col4(input int t, input int c);
    return {img(t, c), img(t + 1, c), img(t + 2, c)};
  endfunction

  // Identity size-4 frame: centres img[1][1..2] at 5,6 and img[2][1..2] at 9,10
  task automatic frame4(input string nm);
    do_start(8'd4, 8'd0);
    for (int t = 0; t < 2; t++)
      for (int c = 0; c < 4; c++)
        feed(nm, col4(t, c), c >= 2, int'(img(t + 1, c - 1)), (t + 1) * 4 + c - 1);
    tick();
    chk({nm, " done vld"}, int'(ValidResult), 0);
  endtask

  initial begin
    tv[0]  = '{"ident",   8'd0, {8'd147,8'd147,8'd147}, {8'd149,8'd150,8'd149}, {8'd19,8'd41,8'd52}, 8'd150};
    tv[1]  = '{"mean",    8'd1, {8'd147,8'd147,8'd147}, {8'd149,8'd150,8'd149}, {8'd19,8'd41,8'd52}, 8'd111};
    tv[2]  = '{"sharp",   8'd2, {8'd147,8'd147,8'd147}, {8'd149,8'd150,8'd149}, {8'd19,8'd41,8'd52}, 8'd255};
    tv[3]  = '{"edge",    8'd3, {8'd147,8'd147,8'd147}, {8'd149,8'd150,8'd149}, {8'd19,8'd41,8'd52}, 8'd255};
    tv[4]  = '{"sharp10", 8'd2, 24'd0, {8'd0,8'd10,8'd0}, 24'd0, 8'd50};
    tv[5]  = '{"edge7",   8'd3, {8'd7,8'd7,8'd7}, {8'd7,8'd7,8'd7}, {8'd7,8'd7,8'd7}, 8'd0};
    tv[6]  = '{"sharpneg",8'd2, {8'd10,8'd10,8'd10}, {8'd10,8'd0,8'd10}, {8'd10,8'd10,8'd10}, 8'd0};
    tv[7]  = '{"mean200", 8'd1, {8'd200,8'd200,8'd200}, {8'd200,8'd200,8'd200}, {8'd200,8'd200,8'd200}, 8'd200};
    tv[8]  = '{"edge8",   8'd3, {8'd1,8'd1,8'd1}, {8'd1,8'd0,8'd1}, {8'd1,8'd1,8'd1}, 8'd8};
    tv[9]  = '{"other9",  8'd9, {8'd147,8'd147,8'd147}, {8'd149,8'd150,8'd149}, {8'd19,8'd41,8'd52}, 8'd150};
    tv[10] = '{"meanflr", 8'd1, {8'd1,8'd1,8'd1}, {8'd1,8'd0,8'd1}, {8'd1,8'd1,8'd1}, 8'd0};
    tv[11] = '{"mean255", 8'd1, {8'd255,8'd255,8'd255}, {8'd255,8'd255,8'd255}, {8'd255,8'd255,8'd255}, 8'd255};
`ifdef IMG_BINARIZE_EN
    tv[12] = '{"bin127",  8'd4, 24'd0, {8'd0,8'd127,8'd0}, 24'd0, 8'd0};
    tv[13] = '{"bin150",  8'd4, 24'd0, {8'd0,8'd150,8'd0}, 24'd0, 8'd255};
`else
    tv[12] = '{"bin127",  8'd4, 24'd0, {8'd0,8'd127,8'd0}, 24'd0, 8'd127};
    tv[13] = '{"bin150",  8'd4, 24'd0, {8'd0,8'd150,8'd0}, 24'd0, 8'd150};
`endif

    rst = 1'b1; start = 1'b0; validData = 1'b0; size = '0; filter = '0;
    pixel_in1 = '0; pixel_in2 = '0; pixel_in3 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset vld", int'(ValidResult), 0);
    chk("reset pix", int'(pixel_out), 0);
    chk("reset addr", int'(Pixel_address), 0);

    // 3x3 frames: exactly one result, centre address 4, then back to IDLE
    for (int i = 0; i < 14; i++) begin
      do_start(8'd3, tv[i].f);
      feed(tv[i].nm, tv[i].c0, 1'b0, 0, 0);
      feed(tv[i].nm, tv[i].c1, 1'b0, 0, 0);
      feed(tv[i].nm, tv[i].c2, 1'b1, int'(tv[i].e), 4);
      tick();
      chk({tv[i].nm, " done vld"}, int'(ValidResult), 0);
    end
    feed("idle after frame", 24'h010203, 1'b0, 0, 0);

    // Size 4 with stall and an ignored start mid-frame
    do_start(8'd4, 8'd0);
    feed("s4 t0c0", col4(0, 0), 1'b0, 0, 0);
    feed("s4 t0c1", col4(0, 1), 1'b0, 0, 0);
    start = 1'b1; size = 8'd3; filter = 8'd1;
    feed("s4 t0c2", col4(0, 2), 1'b1, 12, 5);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall vld", int'(ValidResult), 0);
      chk("stall pix hold", int'(pixel_out), 12);
      chk("stall addr hold", int'(Pixel_address), 5);
    end
    feed("s4 t0c3", col4(0, 3), 1'b1, 13, 6);
    feed("s4 t1c0", col4(1, 0), 1'b0, 0, 0);
    feed("s4 t1c1", col4(1, 1), 1'b0, 0, 0);
    feed("s4 t1c2", col4(1, 2), 1'b1, 22, 9);
    feed("s4 t1c3", col4(1, 3), 1'b1, 23, 10);
    tick();
    chk("s4 done vld", int'(ValidResult), 0);
    feed("s4 idle", col4(0, 2), 1'b0, 0, 0);

    // Out-of-range sizes are ignored
    do_start(8'd2, 8'd0);
    for (int k = 0; k < 3; k++) feed("size2", col4(0, k), 1'b0, 0, 0);
    do_start(8'd17, 8'd0);
    for (int k = 0; k < 3; k++) feed("size17", col4(0, k), 1'b0, 0, 0);

    frame4("s4 plain");

    // Reset after two results aborts the frame
    do_start(8'd4, 8'd0);
    for (int c = 0; c < 4; c++)
      feed("prerst", col4(0, c), c >= 2, int'(img(1, c - 1)), 4 + c - 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst vld", int'(ValidResult), 0);
    chk("midrst pix", int'(pixel_out), 0);
    chk("midrst addr", int'(Pixel_address), 0);
    for (int c = 0; c < 4; c++) feed("postrst", col4(1, c), 1'b0, 0, 0);
    frame4("s4 after rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
